// File: rtl/grant_dispatch_pkg.sv
// grant_dispatch_pkg: shared sizes and FSM state type for the grant dispatcher.
// Used by grant_dispatcher and, when GRANT_CHECK_EN is defined, grant_onehot_check.
package grant_dispatch_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

endpackage

// File: rtl/grant_onehot_check.sv
// grant_onehot_check: flags whether an arbiter grant is trustworthy. The grant
// is consistent only if it is exactly the one-hot decode of the reported index
// and it selects a requester that was present in the request snapshot.
// The module exists only when GRANT_CHECK_EN is defined.
`ifdef GRANT_CHECK_EN
module grant_onehot_check
  import grant_dispatch_pkg::*;
(
  input  logic [NUM_REQ-1:0] grant,
  input  logic [IDX_W-1:0]   index,
  input  logic [NUM_REQ-1:0] requests,
  output logic               consistent
);

  logic [NUM_REQ-1:0] idx_onehot;

  // Decode the index; equality with the grant covers both one-hot and agreement
  always_comb begin
    idx_onehot        = '0;
    idx_onehot[index] = 1'b1;
  end

  assign consistent = (grant == idx_onehot) && ((grant & ~requests) == '0);

endmodule
`endif

// File: rtl/grant_dispatcher.sv
// grant_dispatcher: snapshots pending requests, runs one external-arbiter
// cycle per transfer, forwards the granted requester's payload downstream and
// holds it until accepted. Optional macro GRANT_CHECK_EN adds a grant
// consistency check with a sticky grant_err flag; without it grant_err is 0
// and any nonzero grant is trusted.
module grant_dispatcher
  import grant_dispatch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        arb_requests,
  output logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        arb_grant,
  input  logic [IDX_W-1:0]          arb_index,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      grant_err
);

  state_t             state;
  logic [DATA_W-1:0]  req_word [NUM_REQ];
  logic [NUM_REQ-1:0] idx_onehot;
  logic               grant_ok;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Acceptance pulse pattern for the requester named by the arbiter index
  always_comb begin
    idx_onehot            = '0;
    idx_onehot[arb_index] = 1'b1;
  end

`ifdef GRANT_CHECK_EN
  logic grant_consistent;

  grant_onehot_check u_check (
    .grant      (arb_grant),
    .index      (arb_index),
    .requests   (arb_requests),
    .consistent (grant_consistent)
  );

  // A consistent grant is one-hot, hence nonzero
  assign grant_ok = grant_consistent;

  // Sticky error: a nonzero grant that fails the check; a zero grant is a
  // legitimate withdrawal and is not an error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_err <= 1'b0;
    end else if (state == ST_GRANT && arb_grant != '0 && !grant_consistent) begin
      grant_err <= 1'b1;
    end
  end
`else
  assign grant_ok  = (arb_grant != '0);
  assign grant_err = 1'b0;
`endif

  // Dispatch FSM: IDLE capture -> ARB (enable pulse) -> GRANT (sample) -> SEND
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      arb_requests <= '0;
      arb_enable   <= 1'b0;
      req_ready    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
      busy         <= 1'b0;
    end else begin
      arb_enable <= 1'b0;
      req_ready  <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid != '0) begin
            arb_requests <= req_valid;
            arb_enable   <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_ARB;
          end
        end
        ST_ARB: begin
          state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (grant_ok) begin
            out_data  <= req_word[arb_index];
            out_src   <= arb_index;
            req_ready <= idx_onehot;
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_dispatcher.sv
// tb_grant_dispatcher: directed stimulus with a transaction-timeline model and
// a round-robin arbiter model. Honours GRANT_CHECK_EN like the design.
module tb_grant_dispatcher;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        req_valid = '0;
  logic [4*DATA_W-1:0] req_data = '0;
  logic [3:0]        req_ready;
  logic [3:0]        arb_requests;
  logic              arb_enable;
  logic [3:0]        arb_grant;
  logic [1:0]        arb_index;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              grant_err;

  int errors = 0;
  int checks = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  grant_dispatcher #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .arb_requests (arb_requests),
    .arb_enable   (arb_enable),
    .arb_grant    (arb_grant),
    .arb_index    (arb_index),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_src      (out_src),
    .out_ready    (out_ready),
    .busy         (busy),
    .grant_err    (grant_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter model: round robin starting after the last winner, or a forced answer
  bit         force_en = 1'b0;
  logic [3:0] force_grant = '0;
  logic [1:0] force_index = '0;
  int         rr_last;
  int         arb_pick;

  function automatic int rr_pick(logic [3:0] reqs, int last);
    for (int k = 1; k <= 4; k++)
      if (reqs[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always_comb arb_pick = rr_pick(arb_requests, rr_last);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_grant <= '0;
      arb_index <= '0;
      rr_last   <= 3;
    end else if (arb_enable) begin
      if (force_en) begin
        arb_grant <= force_grant;
        arb_index <= force_index;
      end else if (arb_pick >= 0) begin
        arb_grant <= 4'(1 << arb_pick);
        arb_index <= 2'(arb_pick);
        rr_last   <= arb_pick;
      end else begin
        arb_grant <= '0;
      end
    end else begin
      arb_grant <= '0;
    end
  end

  // Transaction model: capture, two edges later decide on the grant, then hold
  // the transfer until the downstream handshake
  bit         m_busy = 0, m_send = 0, m_err = 0;
  int         m_wait = 0;
  logic [3:0] m_snap = '0;
  logic [7:0] m_data = '0;
  logic [1:0] m_src = '0;
  bit         e_enable = 0;
  logic [3:0] e_ready = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_send <= 0; m_err <= 0; m_wait <= 0;
      m_snap <= '0; m_data <= '0; m_src <= '0;
      e_enable <= 0; e_ready <= '0;
    end else begin
      e_enable <= 0;
      e_ready  <= '0;
      if (!m_busy) begin
        if (req_valid != 4'b0) begin
          m_busy <= 1; m_snap <= req_valid; m_wait <= 2; e_enable <= 1;
        end
      end else if (m_wait == 2) begin
        m_wait <= 1;
      end else if (m_wait == 1) begin
        m_wait <= 0;
        if (arb_grant == 4'b0) begin
          m_busy <= 0;
`ifdef GRANT_CHECK_EN
        end else if (!($onehot(arb_grant) && arb_grant[arb_index] &&
                       ((arb_grant & ~m_snap) == 4'b0))) begin
          m_busy <= 0;
          m_err  <= 1;
`endif
        end else begin
          m_send  <= 1;
          m_data  <= req_data[arb_index*8 +: 8];
          m_src   <= arb_index;
          e_ready <= 4'(1 << arb_index);
        end
      end else if (m_send && out_ready) begin
        m_send <= 0;
        m_busy <= 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_arb_enable", 32'(arb_enable), 32'(e_enable));
    chk("cyc_req_ready", 32'(req_ready), 32'(e_ready));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_send));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_grant_err", 32'(grant_err), 32'(m_err));
    if (m_busy) chk("cyc_arb_requests", 32'(arb_requests), 32'(m_snap));
    if (m_send) begin
      chk("cyc_out_data", 32'(out_data), 32'(m_data));
      chk("cyc_out_src", 32'(out_src), 32'(m_src));
    end
  end

  always @(negedge clk) if (arb_enable === 1'b1) en_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) chk({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en_before;
    logic [1:0] srcs[$];

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_arb_enable", 32'(arb_enable), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_arb_requests", 32'(arb_requests), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_grant_err", 32'(grant_err), 32'd0);
    reset = 1'b1;
    tick();

    // Single request from requester 2
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    en_before = en_count;
    wait_out_valid("t034", n);
    chk("t034_latency", 32'(n), 32'd3);
    chk("t034_out_data", 32'(out_data), 32'hA5);
    chk("t034_out_src", 32'(out_src), 32'd2);
    chk("t034_req_ready", 32'(req_ready), 32'b0100);
    chk("t034_enable_pulses", 32'(en_count - en_before), 32'd1);
    req_valid = 4'b0;
    tick();
    chk("t034_done_valid", 32'(out_valid), 32'd0);
    chk("t034_done_busy", 32'(busy), 32'd0);

    // All four requesting with round-robin arbiter
    do_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'b1111;
    n = 0;
    while (srcs.size() < 5 && n < 60) begin
      tick();
      n++;
      if (out_valid === 1'b1) srcs.push_back(out_src);
    end
    req_valid = 4'b0;
    chk("t035_count", 32'(srcs.size()), 32'd5);
    for (int i = 0; i < 5 && i < srcs.size(); i++)
      chk($sformatf("t035_src%0d", i), 32'(srcs[i]), 32'(i % 4));
    wait_idle("t035");

    // Downstream stall for 10 cycles; request changes ignored meanwhile
    out_ready = 1'b0;
    req_data  = 32'h0000_5A00;
    req_valid = 4'b0010;
    wait_out_valid("t036", n);
    chk("t036_req_ready", 32'(req_ready), 32'b0010);
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      chk("t036_hold_valid", 32'(out_valid), 32'd1);
      chk("t036_hold_data", 32'(out_data), 32'h5A);
      chk("t036_hold_src", 32'(out_src), 32'd1);
      if (i == 5) req_valid = 4'b0;
      tick();
    end
    out_ready = 1'b1;
    chk("t036_last_valid", 32'(out_valid), 32'd1);
    tick();
    chk("t036_done_valid", 32'(out_valid), 32'd0);
    chk("t036_done_busy", 32'(busy), 32'd0);

    // Arbiter reports a two-hot grant
    force_en    = 1'b1;
    force_grant = 4'b0110;
    force_index = 2'd1;
    req_data    = 32'h0000_C300;
    req_valid   = 4'b0110;
    tick();
    tick();
    tick();
`ifdef GRANT_CHECK_EN
    chk("t037_grant_err", 32'(grant_err), 32'd1);
    chk("t037_busy", 32'(busy), 32'd0);
    chk("t037_req_ready", 32'(req_ready), 32'd0);
    chk("t037_out_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b0;
    repeat (4) tick();
    chk("t037_err_sticky", 32'(grant_err), 32'd1);
    chk("t037_idle", 32'(busy), 32'd0);
`else
    chk("t037_out_valid", 32'(out_valid), 32'd1);
    chk("t037_out_src", 32'(out_src), 32'd1);
    chk("t037_out_data", 32'(out_data), 32'hC3);
    chk("t037_req_ready", 32'(req_ready), 32'b0010);
    chk("t037_grant_err", 32'(grant_err), 32'd0);
    req_valid = 4'b0;
    tick();
    chk("t037_idle", 32'(busy), 32'd0);
`endif
    force_en = 1'b0;

    // Reset asserted while in SEND
    out_ready = 1'b0;
    req_data  = 32'h0077_0000;
    req_valid = 4'b0100;
    wait_out_valid("t038", n);
    req_valid = 4'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("t038_out_valid", 32'(out_valid), 32'd0);
    chk("t038_busy", 32'(busy), 32'd0);
    chk("t038_req_ready", 32'(req_ready), 32'd0);
    chk("t038_grant_err", 32'(grant_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t038_no_stale_valid", 32'(out_valid), 32'd0);
      chk("t038_no_stale_ready", 32'(req_ready), 32'd0);
    end

    // Request withdrawn before GRANT; arbiter answers with no grant
    force_en    = 1'b1;
    force_grant = 4'b0;
    force_index = 2'd0;
    req_data    = 32'h0000_00EE;
    req_valid   = 4'b0001;
    tick();
    req_valid = 4'b0;
    tick();
    chk("t039_busy_in_grant", 32'(busy), 32'd1);
    tick();
    chk("t039_busy", 32'(busy), 32'd0);
    chk("t039_out_valid", 32'(out_valid), 32'd0);
    chk("t039_req_ready", 32'(req_ready), 32'd0);
    repeat (3) tick();
    chk("t039_still_idle", 32'(busy), 32'd0);
    chk("t039_no_valid", 32'(out_valid), 32'd0);
    force_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
